// File: rtl/sclk_rx_deserializer.sv
// rtl/sclk_rx_deserializer.sv - serial-clock receive deserializer with idle timeout
//
// Resynchronises an external serial clock and data line into the clk domain,
// samples data MSB first on rising serial-clock edges and presents each
// completed word on data_out together with a one-cycle data_valid strobe.
// A frame that stalls for LIMIT = TIMEOUT_MULT*2*CLK_PER_BIT clk cycles
// without a rising sclk edge is dropped and flagged with frame_err.
//
// Optional build macro: SCLK_RX_PARITY_EN
//   Frames carry one extra trailing even-parity bit; a mismatch pulses
//   parity_err instead of data_valid and leaves data_out untouched.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   enable      receiver enable; low forces IDLE and ignores edges
//   sclk_in     asynchronous serial clock
//   sdata_in    asynchronous serial data
//   data_out    last complete word received
//   data_valid  one-cycle pulse, data_out just updated
//   busy        frame in progress
//   parity_err  one-cycle pulse, parity mismatch (SCLK_RX_PARITY_EN only)
//   frame_err   one-cycle pulse, partial frame aborted by timeout

module sclk_rx_deserializer #(
    parameter int DATA_BITS    = 8,
    parameter int CLK_PER_BIT  = 5,
    parameter int TIMEOUT_MULT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sclk_in,
    input  logic                 sdata_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
`ifdef SCLK_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 frame_err
);

    localparam int LIMIT = TIMEOUT_MULT * 2 * CLK_PER_BIT;
    localparam int BCW   = $clog2(DATA_BITS + 2);
    localparam int TCW   = $clog2(LIMIT + 1);

`ifdef SCLK_RX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif

    localparam logic [BCW-1:0] FRAME_CNT = BCW'(FRAME_BITS);
    localparam logic [TCW-1:0] LIMIT_CNT = TCW'(LIMIT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Two-flop synchronisers; sclk gets a third flop for edge detection.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic sdata_s1, sdata_s2;

    logic [0:0]           state;
    logic [BCW-1:0]       bit_cnt;
    logic [TCW-1:0]       to_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic                 rise;
    logic                 bit_in;
    logic [DATA_BITS-1:0] shift_next;
    logic [BCW-1:0]       cnt_next;
    logic                 last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
        end else begin
            sclk_s1  <= sclk_in;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            sdata_s1 <= sdata_in;
            sdata_s2 <= sdata_s1;
        end
    end

    // sdata travels through the same flop depth as sclk, so s2_sdata is the
    // bit that was on the line when the serial clock rose.
    always_comb begin
        rise       = sclk_s2 & ~sclk_s3;
        bit_in     = sdata_s2;
        // Shift-and-insert written so that DATA_BITS == 1 needs no special slice.
        shift_next = (shift_reg << 1) | DATA_BITS'(bit_in);
        // bit_cnt is always 0 in IDLE, so this also yields 1 on a frame start.
        cnt_next   = bit_cnt + BCW'(1);
        last_bit   = (cnt_next == FRAME_CNT);
    end

    assign busy = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SCLK_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SCLK_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!enable) begin
                // Disabled: drop any partial frame silently.
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                to_cnt    <= '0;
                shift_reg <= '0;
            end else if (rise) begin
                // An edge always wins over a coincident timeout.
                to_cnt <= '0;
                if (last_bit) begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
`ifdef SCLK_RX_PARITY_EN
                    // Final bit is the parity bit; shift_reg already holds the word.
                    if ((^shift_reg) == bit_in) begin
                        data_out   <= shift_reg;
                        data_valid <= 1'b1;
                    end else begin
                        parity_err <= 1'b1;
                    end
`else
                    shift_reg  <= shift_next;
                    data_out   <= shift_next;
                    data_valid <= 1'b1;
`endif
                end else begin
                    state     <= ST_SHIFT;
                    bit_cnt   <= cnt_next;
                    shift_reg <= shift_next;
                end
            end else if (state == ST_SHIFT) begin
                if (to_cnt == LIMIT_CNT) begin
                    frame_err <= 1'b1;
                    state     <= ST_IDLE;
                    bit_cnt   <= '0;
                    to_cnt    <= '0;
                    shift_reg <= '0;
                end else begin
                    to_cnt <= to_cnt + TCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sclk_rx_deserializer.sv
// tb/tb_sclk_rx_deserializer.sv - self-checking bench for sclk_rx_deserializer

module tb_sclk_rx_deserializer;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sclk_in;
    logic       sdata_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
`ifdef SCLK_RX_PARITY_EN
    logic       parity_err;
`endif

    sclk_rx_deserializer #(
        .DATA_BITS   (8),
        .CLK_PER_BIT (HALF),
        .TIMEOUT_MULT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sclk_in   (sclk_in),
        .sdata_in  (sdata_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
`ifdef SCLK_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int valid_cyc = -1;
    int err_cnt = 0;
    int err_cyc = -1;
    int perr_cnt = 0;
    int both_seen = 0;
    int last_k = 0;

    // Pulse monitor, sampling 1 time unit after every posedge.
    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (data_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (frame_err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (data_valid === 1'b1 && frame_err === 1'b1) both_seen = 1;
`ifdef SCLK_RX_PARITY_EN
        if (parity_err === 1'b1) perr_cnt = perr_cnt + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called on a negedge; ends on a negedge with sclk high. last_k is the
    // posedge at which the DUT first samples this bit's sclk high.
    task automatic send_bit(input logic b);
        sdata_in = b;
        sclk_in  = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk_in = 1'b1;
        last_k  = cyc + 1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic par);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef SCLK_RX_PARITY_EN
        send_bit(par);
`endif
    endtask

    task automatic idle(input int n);
        sclk_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] word;
        logic       par;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] exp_word;
        int v0, e0, p0;

        // Back-to-back frames; par is the even-parity bit of word.
        vecs.push_back('{8'h00, 1'b0, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 8'h80, 1'b0});
`ifdef SCLK_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b0, 8'h07, 1'b1});
`endif

        rst = 1'b1; enable = 1'b0; sclk_in = 1'b0; sdata_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0; enable = 1'b1;
        idle(5);

        // Test 1: 0xA5, latency and busy window.
        v0 = valid_cnt;
        exp_word = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(exp_word[i]);
        check("t1_busy_mid", 32'(busy), 32'h1);
        check("t1_no_early_valid", 32'(valid_cnt - v0), 32'h0);
        send_bit(exp_word[0]);
`ifdef SCLK_RX_PARITY_EN
        send_bit(^exp_word);
`endif
        check("t1_valid_count", 32'(valid_cnt - v0), 32'h1);
        check("t1_valid_latency", 32'(valid_cyc - last_k), 32'h2);
        check("t1_data", 32'(data_out), 32'hA5);
        check("t1_busy_done", 32'(busy), 32'h0);

        // Test 2 (+ parity vectors): table of back-to-back frames, no gaps.
        e0 = err_cnt;
        foreach (vecs[n]) begin
            v0 = valid_cnt;
            p0 = perr_cnt;
            send_frame(vecs[n].word, vecs[n].par);
            check($sformatf("tbl%0d_valid", n), 32'(valid_cnt - v0), 32'(vecs[n].exp_valid));
            check($sformatf("tbl%0d_data", n), 32'(data_out), 32'(vecs[n].exp_data));
            check($sformatf("tbl%0d_perr", n), 32'(perr_cnt - p0), 32'(vecs[n].exp_perr));
            exp_word = vecs[n].exp_data;
        end
        check("tbl_no_frame_err", 32'(err_cnt - e0), 32'h0);
        idle(5);

        // Test 3: 3 bits then stall. Bit 3 enters the FSM at last_k+2; the
        // counter hits LIMIT=40 at last_k+42 and the error registers next.
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        idle(60);
        check("t3_err_count", 32'(err_cnt - e0), 32'h1);
        check("t3_err_time", 32'(err_cyc - last_k), 32'd43);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'h0);
        check("t3_data_held", 32'(data_out), 32'(exp_word));
        check("t3_busy", 32'(busy), 32'h0);
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b0);
        check("t3_valid_3c", 32'(valid_cnt - v0), 32'h1);
        check("t3_data_3c", 32'(data_out), 32'h3C);
        idle(5);

        // Test 4: reset mid-frame after 4 bits of 0xF0.
        v0 = valid_cnt; e0 = err_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_data_out", 32'(data_out), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_valid", 32'(data_valid), 32'h0);
        check("t4_frame_err", 32'(frame_err), 32'h0);
        idle(3);
        send_frame(8'h81, 1'b0);
        check("t4_valid_81", 32'(valid_cnt - v0), 32'h1);
        check("t4_no_err", 32'(err_cnt - e0), 32'h0);
        check("t4_data_81", 32'(data_out), 32'h81);
        idle(5);

        // Test 5: disable after 5 bits, re-enable while sclk is high.
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_busy_off", 32'(busy), 32'h0);
        repeat (50) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_valid", 32'(valid_cnt - v0), 32'h0);
        check("t5_no_err", 32'(err_cnt - e0), 32'h0);
        check("t5_busy_reen", 32'(busy), 32'h0);
        send_frame(8'h5A, 1'b0);
        check("t5_valid_5a", 32'(valid_cnt - v0), 32'h1);
        check("t5_data_5a", 32'(data_out), 32'h5A);
        idle(5);

        check("never_valid_and_err", 32'(both_seen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sclk_rx_deserializer.md
Name: sclk_rx_deserializer

Overview:
- Receive-side counterpart of the divided serial clock produced by the team's clock generator.
- Takes an external serial clock line plus a data line from a sensor link and resynchronises both into the system clock domain.
- Samples data on rising serial-clock edges, MSB first, and delivers parallel words with a one-cycle valid strobe.
- Aborts stalled frames with an idle timeout. Sits between the pad-level serial link and the sensor data path.

Parameters:
- DATA_BITS, 8: bits per frame (excluding parity).
- CLK_PER_BIT, 5: nominal serial-clock half-period in clk cycles, matching the transmit-side divider; must be >= 2.
- TIMEOUT_MULT, 4: idle limit LIMIT = TIMEOUT_MULT*2*CLK_PER_BIT clk cycles without a rising sclk edge (default 40).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  receiver enable.
- sclk_in  input  1  asynchronous serial clock.
- sdata_in  input  1  asynchronous serial data.
- data_out  output  DATA_BITS  last complete word received.
- data_valid  output  1  one-cycle pulse: data_out just updated.
- busy  output  1  frame in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse: partial frame aborted by timeout.

Behaviour:
- Reset (rst=1 at posedge): data_out=0, data_valid=0, busy=0, frame_err=0, state=IDLE, bit counter=0, timeout counter=0, shift register=0, synchroniser flops=0.
- Reset has priority over everything; asserting it mid-frame discards the partial frame and produces no pulse.
- Synchronisation:
  - sclk_in and sdata_in each pass through two flops (s1, s2); a third flop s3 holds the previous s2 of sclk.
  - rise = s2_sclk & ~s3_sclk. Bit sampled = s2_sdata on the same cycle.
  - Synchronisers run regardless of enable.
- FSM IDLE:
  - busy=0.
  - On rise with enable=1: shift in bit, bit_cnt=1, timeout counter=0, go to SHIFT.
  - If DATA_BITS==1, complete immediately as below.
- FSM SHIFT:
  - busy=1.
  - On rise: shift register <= {shift[DATA_BITS-2:0], bit}, bit_cnt+1, timeout counter cleared.
  - On the rise carrying bit DATA_BITS: data_out <= completed word, data_valid=1 for exactly that cycle, bit_cnt=0, go to IDLE.
- Completion latency: sclk_in first sampled high at posedge k gives data_valid high after posedge k+2.
- Timeout:
  - Timeout counter increments every cycle in SHIFT without rise.
  - Reaching LIMIT: frame_err=1 for one cycle, shift register and bit_cnt cleared, go to IDLE.
  - data_out is unchanged.
  - If rise and counter==LIMIT coincide, the edge wins: the counter is cleared and there is no error.
- enable=0:
  - Forces IDLE at the next posedge and clears bit_cnt and timeout counter.
  - No data_valid or frame_err pulses; data_out holds.
  - Edges seen while disabled are ignored.
  - If sclk is already high when enable rises, no edge is generated.
- Back-to-back frames: the next rise after completion starts a new frame with no gap cycles required.
- data_valid and frame_err are never high in the same cycle.
- Counter widths: $clog2(DATA_BITS+2) for bit_cnt and $clog2(LIMIT+1) for the timeout counter; neither wraps.

Optional Feature:
- SCLK_RX_PARITY_EN defined:
  - Frame is DATA_BITS+1 bits; the final bit is even parity over the data bits.
  - Adds output port parity_err (1 bit, reset 0).
  - On completion with correct parity: normal data_valid.
  - On mismatch: parity_err pulses one cycle, data_valid stays 0, data_out is unchanged.
- Not defined: no parity_err port; frames are DATA_BITS bits.

Test Plan:
1. Defaults; drive 0xA5 MSB-first, half-period 5 clk -> single data_valid pulse 2 cycles after the 8th sclk_in rise is sampled, data_out=0xA5, busy high from 1st rise until completion.
2. Back-to-back 0x00 then 0xFF, no gap -> exactly two data_valid pulses, data_out 0x00 then 0xFF, no frame_err.
3. Send 3 bits then hold sclk low -> frame_err pulse 40 cycles after the 3rd rise cycle, no data_valid, data_out unchanged; then a full 0x3C -> data_valid with 0x3C.
4. rst high for 1 cycle after 4 bits of 0xF0 -> all outputs 0 next cycle; then send 0x81 -> data_out=0x81 with a single pulse.
5. Drop enable after 5 bits, raise it while sclk_in is high, then send 0x5A -> no pulses during the abort, no spurious edge, data_out=0x5A.
6. With SCLK_RX_PARITY_EN: send 0x07 + parity 1 -> data_valid, data_out=0x07; send 0x07 + parity 0 -> parity_err pulse, data_valid=0, data_out stays 0x07.
